// File: rtl/exec_sequencer_if.sv
// rtl/exec_sequencer_if.sv - instruction handshake and execute-unit bus for exec_sequencer
//
// Signals:
//   instr_valid   source -> sequencer  instruction word available
//   instr_ready   sequencer -> source  instruction accepted this cycle (FETCH only)
//   instr[7:0]    source -> sequencer  [7:4] opcode, [3:0] register address
//   ex_opcode     sequencer -> exec    captured opcode
//   ex_operand    sequencer -> exec    captured register address
//   ex_data       sequencer -> exec    rf[ex_operand], combinational
//   ex_result     exec -> sequencer    registered result, one-cycle latency
//   ex_write_addr exec -> sequencer    registered destination address
//
// Modports: master = sequencer side, slave = instruction source / execute unit side.

interface exec_sequencer_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [3:0] ex_opcode;
  logic [3:0] ex_operand;
  logic [7:0] ex_data;
  logic [7:0] ex_result;
  logic [3:0] ex_write_addr;

  modport master (
    input  instr_valid,
    input  instr,
    input  ex_result,
    input  ex_write_addr,
    output instr_ready,
    output ex_opcode,
    output ex_operand,
    output ex_data
  );

  modport slave (
    output instr_valid,
    output instr,
    output ex_result,
    output ex_write_addr,
    input  instr_ready,
    input  ex_opcode,
    input  ex_operand,
    input  ex_data
  );
endinterface

// File: rtl/exec_sequencer.sv
// rtl/exec_sequencer.sv - FETCH/ISSUE/WB instruction sequencer with 16x8 register file
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             leaves IDLE or HALTED, ignored elsewhere
//   bus               exec_sequencer_if.master (instruction handshake + execute unit)
//   busy              high in FETCH, ISSUE, WB
//   halted            high in HALTED
//   dbg_addr/dbg_data combinational register-file read port
//   retire_cnt        retired-instruction counter, only when EXEC_SEQ_PERF_EN is defined
//
// Parameter RF_INIT: reset value of every register-file entry.
// Optional feature macro: EXEC_SEQ_PERF_EN (adds retire_cnt).

module exec_sequencer #(
  parameter logic [7:0] RF_INIT = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  exec_sequencer_if.master  bus,
  output logic              busy,
  output logic              halted,
  input  logic [3:0]        dbg_addr,
  output logic [7:0]        dbg_data
`ifdef EXEC_SEQ_PERF_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WB,
    S_HALTED
  } state_t;

  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  state_t     state_next;
  logic [7:0] instr_q;
  logic [7:0] rf [16];
  logic       capture;
  logic       wb_en;
  logic       ready;

  // State register and captured instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      instr_q <= 8'h00;
    end else begin
      state <= state_next;
      if (capture) begin
        instr_q <= bus.instr;
      end
    end
  end

  // Register file. Reset wins over a write pending in WB, so an
  // interrupted instruction leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        rf[i] <= RF_INIT;
      end
    end else if (wb_en) begin
      rf[bus.ex_write_addr] <= bus.ex_result;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    capture    = 1'b0;
    wb_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          capture = 1'b1;
          // HALT words are captured (visible on ex_opcode) but never reach WB.
          if (bus.instr[7:4] == OP_HALT) begin
            state_next = S_HALTED;
          end else begin
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Execute unit samples ex_* at this closing edge.
        state_next = S_WB;
      end
      S_WB: begin
        wb_en      = 1'b1;
        state_next = S_FETCH;
      end
      S_HALTED: begin
        if (start) begin
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.instr_ready = ready;
  assign bus.ex_opcode   = instr_q[7:4];
  assign bus.ex_operand  = instr_q[3:0];
  // Both read ports see the pre-edge contents while WB is writing.
  assign bus.ex_data     = rf[instr_q[3:0]];
  assign dbg_data        = rf[dbg_addr];

  assign busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WB);
  assign halted = (state == S_HALTED);

`ifdef EXEC_SEQ_PERF_EN
  logic [15:0] retire_q;

  // Counts completed write-backs; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_q <= 16'h0000;
    end else if (wb_en) begin
      retire_q <= retire_q + 16'h0001;
    end
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// tb/tb_exec_sequencer.sv - scoreboard testbench for exec_sequencer

module tb_exec_sequencer;

  localparam logic [7:0] RF_INIT = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       halted;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;
`ifdef EXEC_SEQ_PERF_EN
  logic [15:0] retire_cnt;
`endif

  exec_sequencer_if bus ();

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] val;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] m_rf [16];

  always #5 clk = ~clk;

  exec_sequencer #(.RF_INIT(RF_INIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .halted     (halted),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
`ifdef EXEC_SEQ_PERF_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  // Execute unit: 1 = INC, 2 = DEC, 3 = NOT, anything else passes data through.
  function automatic logic [7:0] ex_fn(input logic [3:0] op, input logic [7:0] d);
    case (op)
      4'h1:    ex_fn = d + 8'h01;
      4'h2:    ex_fn = d - 8'h01;
      4'h3:    ex_fn = ~d;
      default: ex_fn = d;
    endcase
  endfunction

  always @(posedge clk) begin
    bus.ex_result     <= ex_fn(bus.ex_opcode, bus.ex_data);
    bus.ex_write_addr <= bus.ex_operand;
  end

  // Drives one word at a FETCH negedge, records the expected write, returns at the next negedge.
  task automatic drive_instr(input logic [7:0] w);
    exp_t e;
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    if (w[7:4] != 4'hF) begin
      e.addr = w[3:0];
      e.val  = ex_fn(w[7:4], m_rf[w[3:0]]);
      m_rf[w[3:0]] = e.val;
      sb.push_back(e);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = RF_INIT;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = 8'h00;
    dbg_addr = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.instr_ready, busy, halted} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 000", {bus.instr_ready, busy, halted});
    end
    n_checks++;
    if ({bus.ex_opcode, bus.ex_operand} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_instr: got %h expected 00", {bus.ex_opcode, bus.ex_operand});
    end
`ifdef EXEC_SEQ_PERF_EN
    n_checks++;
    if (retire_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_retire: got %h expected 0000", retire_cnt);
    end
`endif
    for (int i = 0; i < 16; i++) begin
      dbg_addr = i[3:0];
      #1;
      n_checks++;
      if (dbg_data !== RF_INIT) begin
        n_fail++;
        $display("FAIL reset_rf[%0d]: got %h expected %h", i, dbg_data, RF_INIT);
      end
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_inc();
    exp_t e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({bus.instr_ready, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL fetch_entry: ready/busy got %b expected 11", {bus.instr_ready, busy});
    end
    drive_instr(8'h13);
    n_checks++;
    if ({bus.instr_ready, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL ready_one_cycle: ready/busy got %b expected 01", {bus.instr_ready, busy});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.ex_opcode, bus.ex_operand} !== 8'h13) begin
      n_fail++;
      $display("FAIL ex_hold: got %h expected 13", {bus.ex_opcode, bus.ex_operand});
    end
    e = sb.pop_front();
    dbg_addr = e.addr;
    #1;
    n_checks++;
    if (dbg_data !== e.val || dbg_data !== 8'h01) begin
      n_fail++;
      $display("FAIL inc_r3: got %h expected %h", dbg_data, e.val);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive_instr(8'h25);
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    dbg_addr = e.addr;
    #1;
    n_checks++;
    if (dbg_data !== e.val) begin
      n_fail++;
      $display("FAIL dec_r5_first: got %h expected %h", dbg_data, e.val);
    end
    drive_instr(8'h25);
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    dbg_addr = e.addr;
    #1;
    n_checks++;
    if (dbg_data !== e.val || dbg_data !== 8'hFE) begin
      n_fail++;
      $display("FAIL dec_r5_second: got %h expected %h", dbg_data, e.val);
    end
  endtask

  task automatic test_dbg_during_wb();
    exp_t       e;
    logic [7:0] old;
    old = m_rf[5];
    drive_instr(8'h35);
    @(negedge clk);
    dbg_addr = 4'h5;
    #1;
    n_checks++;
    if (dbg_data !== old) begin
      n_fail++;
      $display("FAIL dbg_old_in_wb: got %h expected %h", dbg_data, old);
    end
    @(negedge clk);
    e = sb.pop_front();
    dbg_addr = e.addr;
    #1;
    n_checks++;
    if (dbg_data !== e.val) begin
      n_fail++;
      $display("FAIL not_r5: got %h expected %h", dbg_data, e.val);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if ({bus.instr_ready, busy} !== 2'b11) begin
        n_fail++;
        $display("FAIL stall_fetch: ready/busy got %b expected 11", {bus.instr_ready, busy});
      end
    end
    dbg_addr = 4'h7;
    #1;
    n_checks++;
    if (dbg_data !== m_rf[7]) begin
      n_fail++;
      $display("FAIL stall_r7: got %h expected %h", dbg_data, m_rf[7]);
    end
    drive_instr(8'h07);
    repeat (2) @(negedge clk);
    e = sb.pop_front();
    dbg_addr = e.addr;
    #1;
    n_checks++;
    if (dbg_data !== e.val) begin
      n_fail++;
      $display("FAIL pass_r7: got %h expected %h", dbg_data, e.val);
    end
  endtask

  task automatic test_start_ignored();
    exp_t e;
    drive_instr(8'h14);
    start = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.instr_ready, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_in_issue_wb: ready/busy got %b expected 11", {bus.instr_ready, busy});
    end
    @(negedge clk);
    n_checks++;
    if ({bus.instr_ready, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL start_in_fetch: ready/busy got %b expected 11", {bus.instr_ready, busy});
    end
    start = 1'b0;
    e = sb.pop_front();
    dbg_addr = e.addr;
    #1;
    n_checks++;
    if (dbg_data !== e.val) begin
      n_fail++;
      $display("FAIL inc_r4: got %h expected %h", dbg_data, e.val);
    end
  endtask

  task automatic test_halt();
    drive_instr(8'hF0);
    n_checks++;
    if ({halted, busy, bus.instr_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL halt_flags: got %b expected 100", {halted, busy, bus.instr_ready});
    end
    bus.instr_valid = 1'b1;
    bus.instr       = 8'h13;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({halted, bus.instr_ready, bus.ex_opcode} !== {2'b10, 4'hF}) begin
      n_fail++;
      $display("FAIL halt_ignore_valid: got %b expected 101111", {halted, bus.instr_ready, bus.ex_opcode});
    end
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    for (int a = 0; a < 4; a++) begin
      dbg_addr = a[3:0];
      #1;
      n_checks++;
      if (dbg_data !== m_rf[a]) begin
        n_fail++;
        $display("FAIL halt_rf[%0d]: got %h expected %h", a, dbg_data, m_rf[a]);
      end
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if ({halted, busy, bus.instr_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL halt_restart: got %b expected 011", {halted, busy, bus.instr_ready});
    end
  endtask

`ifdef EXEC_SEQ_PERF_EN
  task automatic test_perf();
    exp_t e;
    force dut.retire_q = 16'hFFFF;
    #1;
    release dut.retire_q;
    #1;
    n_checks++;
    if (retire_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL retire_preload: got %h expected FFFF", retire_cnt);
    end
    drive_instr(8'h11);
    repeat (2) @(negedge clk);
    n_checks++;
    if (retire_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL retire_wrap: got %h expected 0000", retire_cnt);
    end
    e = sb.pop_front();
    dbg_addr = e.addr;
    #1;
    n_checks++;
    if (dbg_data !== e.val) begin
      n_fail++;
      $display("FAIL inc_r1: got %h expected %h", dbg_data, e.val);
    end
    drive_instr(8'hF0);
    @(negedge clk);
    n_checks++;
    if (retire_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL retire_halt: got %h expected 0000", retire_cnt);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
`endif

  task automatic test_reset_in_wb();
    drive_instr(8'h1A);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, halted, bus.instr_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_wb_flags: got %b expected 000", {busy, halted, bus.instr_ready});
    end
    model_reset();
    @(negedge clk);
    dbg_addr = 4'hA;
    #1;
    n_checks++;
    if (dbg_data !== RF_INIT) begin
      n_fail++;
      $display("FAIL rst_wb_r10: got %h expected %h", dbg_data, RF_INIT);
    end
    dbg_addr = 4'h5;
    #1;
    n_checks++;
    if (dbg_data !== RF_INIT) begin
      n_fail++;
      $display("FAIL rst_wb_r5: got %h expected %h", dbg_data, RF_INIT);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, halted, bus.instr_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_wb_idle: got %b expected 000", {busy, halted, bus.instr_ready});
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_back_to_back();
    test_dbg_during_wb();
    test_stall();
    test_start_ignored();
    test_halt();
`ifdef EXEC_SEQ_PERF_EN
    test_perf();
`endif
    test_reset_in_wb();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
